// File: rtl/sampler_pkg.sv
// Shared definitions for the sampler trigger front end.
package sampler_pkg;

  localparam int unsigned StateBits = 2;

  typedef logic [StateBits-1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StArmed = 2'd1;
  localparam state_t StDelay = 2'd2;
  localparam state_t StFired = 2'd3;

endpackage

// File: rtl/trigger_match.sv
// Previous-sample register plus combinational level/edge pattern compare.
module trigger_match #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] probe_i,
  input  logic [Width-1:0] mask_i,
  input  logic [Width-1:0] value_i,
  input  logic [Width-1:0] edge_sel_i,
  input  logic             edge_valid_i,
  output logic [Width-1:0] prev_o,
  output logic             match_o
);

  logic [Width-1:0] prev_q;
  logic [Width-1:0] diff;
  logic [Width-1:0] edge_bits;
  logic             level_ok;
  logic             edge_ok;

  // Previous-cycle probe; doubles as the registered bus forwarded to the sampler.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= probe_i;
    end
  end

  // Level bits must equal value; edge bits must equal value now and differ from it last cycle.
  always_comb begin
    diff      = probe_i ^ value_i;
    edge_bits = mask_i & edge_sel_i;
    level_ok  = (diff & mask_i & ~edge_sel_i) == '0;
    // With no edge bits selected the edge term is vacuously true, even before prev is valid.
    edge_ok   = (edge_bits == '0) ||
                (edge_valid_i && ((diff & edge_bits) == '0) &&
                 (((prev_q ^ value_i) & edge_bits) == edge_bits));
    match_o   = level_ok && edge_ok;
  end

  assign prev_o = prev_q;

endmodule

// File: rtl/sampler_trigger.sv
// Trigger front end: registers the probe bus and gates the sampler's write enable
// behind a programmed pattern match, occurrence count and post-match delay.
module sampler_trigger
  import sampler_pkg::*;
#(
  parameter int unsigned width     = 32,
  parameter int unsigned countBits = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic [width-1:0]     probe,
  input  logic [width-1:0]     cfg_mask,
  input  logic [width-1:0]     cfg_value,
  input  logic [width-1:0]     cfg_edge,
  input  logic [countBits-1:0] cfg_count,
  input  logic [countBits-1:0] cfg_delay,
  output logic [width-1:0]     w_in,
  output logic                 w_enable,
  output logic                 armed,
  output logic                 triggered,
  output logic [31:0]          trig_time
);

  state_t               state_q, state_d;
  logic [width-1:0]     mask_q, mask_d;
  logic [width-1:0]     value_q, value_d;
  logic [width-1:0]     edge_q, edge_d;
  logic [countBits-1:0] need_q, need_d;
  logic [countBits-1:0] delay_q, delay_d;
  logic [countBits-1:0] occ_q, occ_d;
  logic [countBits-1:0] dly_q, dly_d;
  logic [31:0]          trig_time_q, trig_time_d;
  logic                 triggered_q, triggered_d;
  logic                 first_q, first_d;
  logic                 match;

  trigger_match #(
    .Width(width)
  ) u_match (
    .clk         (clk),
    .reset       (reset),
    .probe_i     (probe),
    .mask_i      (mask_q),
    .value_i     (value_q),
    .edge_sel_i  (edge_q),
    .edge_valid_i(~first_q),
    .prev_o      (w_in),
    .match_o     (match)
  );

  // Next-state: disarm beats arm, arm restarts from any state, otherwise run the FSM.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    value_d     = value_q;
    edge_d      = edge_q;
    need_d      = need_q;
    delay_d     = delay_q;
    occ_d       = occ_q;
    dly_d       = dly_q;
    trig_time_d = trig_time_q;
    triggered_d = triggered_q;
    first_d     = 1'b0;

    if (disarm) begin
      state_d = StIdle;
    end else if (arm) begin
      state_d     = StArmed;
      mask_d      = cfg_mask;
      value_d     = cfg_value;
      edge_d      = cfg_edge;
      need_d      = (cfg_count == '0) ? countBits'(1) : cfg_count;
      delay_d     = cfg_delay;
      occ_d       = '0;
      dly_d       = '0;
      trig_time_d = '0;
      triggered_d = 1'b0;
      first_d     = 1'b1;
    end else begin
      unique case (state_q)
        StArmed: begin
          // Counts every armed cycle including the final match, so it reads arm-to-match distance.
          if (trig_time_q != '1) begin
            trig_time_d = trig_time_q + 32'd1;
          end
          if (match) begin
            occ_d = occ_q + countBits'(1);
            if (occ_q + countBits'(1) == need_q) begin
              triggered_d = 1'b1;
              state_d     = (delay_q == '0) ? StFired : StDelay;
              // Loaded with D-1 so the last DELAY cycle sees zero and hands over to FIRED.
              dly_d       = delay_q - countBits'(1);
            end
          end
        end
        StDelay: begin
          if (dly_q == '0) begin
            state_d = StFired;
          end else begin
            dly_d = dly_q - countBits'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      value_q     <= '0;
      edge_q      <= '0;
      need_q      <= '0;
      delay_q     <= '0;
      occ_q       <= '0;
      dly_q       <= '0;
      trig_time_q <= '0;
      triggered_q <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      value_q     <= value_d;
      edge_q      <= edge_d;
      need_q      <= need_d;
      delay_q     <= delay_d;
      occ_q       <= occ_d;
      dly_q       <= dly_d;
      trig_time_q <= trig_time_d;
      triggered_q <= triggered_d;
      first_q     <= first_d;
    end
  end

  assign w_enable  = (state_q == StFired);
  assign armed     = (state_q == StArmed) || (state_q == StDelay);
  assign triggered = triggered_q;
  assign trig_time = trig_time_q;

endmodule

// File: tb/tb_sampler_trigger.sv
// Self-checking bench for sampler_trigger against an event-level reference model.
module tb_sampler_trigger;

  localparam int unsigned W  = 32;
  localparam int unsigned CB = 16;

  logic          clk = 1'b0;
  logic          reset, arm, disarm;
  logic [W-1:0]  probe, cfg_mask, cfg_value, cfg_edge;
  logic [CB-1:0] cfg_count, cfg_delay;
  logic [W-1:0]  w_in;
  logic          w_enable, armed, triggered;
  logic [31:0]   trig_time;

  sampler_trigger #(
    .width    (W),
    .countBits(CB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .arm      (arm),
    .disarm   (disarm),
    .probe    (probe),
    .cfg_mask (cfg_mask),
    .cfg_value(cfg_value),
    .cfg_edge (cfg_edge),
    .cfg_count(cfg_count),
    .cfg_delay(cfg_delay),
    .w_in     (w_in),
    .w_enable (w_enable),
    .armed    (armed),
    .triggered(triggered),
    .trig_time(trig_time)
  );

  always #5 clk = ~clk;

  int unsigned n_vec, n_err;
  longint      cyc;

  // Reference model: a capture session, its arm cycle and the cycle of the final match.
  bit         m_active, m_trig;
  longint     m_arm, m_final, m_tt;
  int         m_matches, m_need, m_delay;
  logic [W-1:0] m_mask, m_val, m_edg, m_prev;

  function automatic bit model_match(input logic [W-1:0] p, input bit first);
    for (int i = 0; i < W; i++) begin
      if (m_mask[i]) begin
        if (p[i] !== m_val[i]) return 1'b0;
        if (m_edg[i] && (first || m_prev[i] === m_val[i])) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [W+34:0] expected();
    bit en;
    en = m_active && (m_final >= 0) && (cyc >= m_final + 1 + m_delay);
    return {m_prev, en, m_active && !en, m_trig, 32'(m_tt)};
  endfunction

  task automatic tick(input logic a, input logic d, input logic [W-1:0] p, input logic r);
    arm = a; disarm = d; probe = p; reset = r;
    @(posedge clk);
    if (r) begin
      m_active = 1'b0; m_trig = 1'b0; m_tt = 0; m_final = -1; m_prev = '0;
    end else begin
      if (d) begin
        m_active = 1'b0;
      end else if (a) begin
        m_active = 1'b1; m_mask = cfg_mask; m_val = cfg_value; m_edg = cfg_edge;
        m_need = (cfg_count == 0) ? 1 : int'(cfg_count);
        m_delay = int'(cfg_delay);
        m_arm = cyc; m_matches = 0; m_final = -1; m_trig = 1'b0; m_tt = 0;
      end else if (m_active && m_final < 0) begin
        m_tt = cyc - m_arm;
        if (model_match(p, cyc == m_arm + 1)) begin
          m_matches++;
          if (m_matches >= m_need) begin
            m_final = cyc; m_trig = 1'b1;
          end
        end
      end
      m_prev = p;
    end
    cyc++;
    #1;
  endtask

  task automatic set_cfg(input logic [W-1:0] mk, input logic [W-1:0] v, input logic [W-1:0] e,
                         input int cnt, input int dl);
    cfg_mask = mk; cfg_value = v; cfg_edge = e; cfg_count = CB'(cnt); cfg_delay = CB'(dl);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(i == 2, 1'b0, $urandom, 1'b1);
      n_vec++;
      if ({w_in, w_enable, armed, triggered, trig_time} !== expected()) begin
        n_err++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", cyc,
                 {w_in, w_enable, armed, triggered, trig_time}, expected());
      end
    end
    n_vec++;
    if (armed !== 1'b0 || w_in !== '0) begin
      n_err++;
      $display("FAIL reset_beats_arm got armed=%b w_in=%h exp armed=0 w_in=0", armed, w_in);
    end
  endtask

  task automatic test_level();
    bit seen = 1'b0;
    set_cfg(32'hFF, 32'h5A, 32'h0, 1, 0);
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 128; i++) begin
      tick(1'b0, 1'b0, W'(i), 1'b0);
      n_vec++;
      if ({w_in, w_enable, armed, triggered, trig_time} !== expected()) begin
        n_err++;
        $display("FAIL level cyc=%0d got=%h exp=%h", cyc,
                 {w_in, w_enable, armed, triggered, trig_time}, expected());
      end
      if (w_enable && !seen) begin
        seen = 1'b1;
        n_vec++;
        if (w_in !== 32'h5A || triggered !== 1'b1) begin
          n_err++;
          $display("FAIL level_first_sample got w_in=%h trig=%b exp w_in=5a trig=1", w_in, triggered);
        end
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL level_fired got w_enable=0 exp w_enable=1");
    end
  endtask

  task automatic test_edge();
    set_cfg(32'h1, 32'h1, 32'h1, 1, 0);
    tick(1'b0, 1'b0, $urandom | 32'h1, 1'b0);
    tick(1'b1, 1'b0, $urandom | 32'h1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] p;
      p = (i == 5) ? ($urandom & ~32'h1) : ($urandom | 32'h1);
      tick(1'b0, 1'b0, p, 1'b0);
      n_vec++;
      if ({w_in, w_enable, armed, triggered, trig_time} !== expected()) begin
        n_err++;
        $display("FAIL edge cyc=%0d got=%h exp=%h", cyc,
                 {w_in, w_enable, armed, triggered, trig_time}, expected());
      end
      // Samples 0..5 never rise into bit0=1; sample 6 is the 0->1 edge.
      if (i == 5 || i == 6) begin
        n_vec++;
        if (w_enable !== (i == 6) || triggered !== (i == 6)) begin
          n_err++;
          $display("FAIL edge_timing i=%0d got en=%b trig=%b exp %b", i, w_enable, triggered, i == 6);
        end
      end
    end
  endtask

  task automatic test_count_delay();
    int first_en = -1;
    set_cfg(32'hFF, 32'h33, 32'h0, 3, 4);
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] p;
      p = (i % 2 == 0) ? 32'h33 : (32'h33 ^ W'($urandom_range(1, 255)));
      tick(1'b0, 1'b0, p, 1'b0);
      n_vec++;
      if ({w_in, w_enable, armed, triggered, trig_time} !== expected()) begin
        n_err++;
        $display("FAIL count_delay cyc=%0d got=%h exp=%h", cyc,
                 {w_in, w_enable, armed, triggered, trig_time}, expected());
      end
      if (w_enable && first_en < 0) first_en = i;
    end
    n_vec++;
    if (first_en != 8) begin
      n_err++;
      $display("FAIL count_delay_first got sample=%0d exp sample=8", first_en);
    end
  endtask

  task automatic test_abort();
    bit ever = 1'b0;
    set_cfg(32'hFF, 32'hC3, 32'h0, 1, 0);
    tick(1'b1, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0);
    tick(1'b1, 1'b1, '0, 1'b0);
    n_vec++;
    if (armed !== 1'b0) begin
      n_err++;
      $display("FAIL abort_armed got armed=%b exp armed=0", armed);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 32'hC3, 1'b0);
      ever |= w_enable;
      n_vec++;
      if ({w_in, w_enable, armed, triggered, trig_time} !== expected()) begin
        n_err++;
        $display("FAIL abort cyc=%0d got=%h exp=%h", cyc,
                 {w_in, w_enable, armed, triggered, trig_time}, expected());
      end
    end
    n_vec++;
    if (ever) begin
      n_err++;
      $display("FAIL abort_enable got w_enable=1 exp w_enable=0");
    end
  endtask

  task automatic test_rearm_reset();
    set_cfg(32'h0, 32'h0, 32'h0, 1, 0);
    tick(1'b1, 1'b0, $urandom, 1'b0);
    tick(1'b0, 1'b0, $urandom, 1'b0);
    n_vec++;
    if (w_enable !== 1'b1 || triggered !== 1'b1) begin
      n_err++;
      $display("FAIL rearm_fire got en=%b trig=%b exp en=1 trig=1", w_enable, triggered);
    end
    set_cfg(32'hFF, 32'hEE, 32'h0, 1, 0);
    tick(1'b1, 1'b0, '0, 1'b0);
    n_vec++;
    if (w_enable !== 1'b0 || triggered !== 1'b0 || armed !== 1'b1 || trig_time !== 32'd0) begin
      n_err++;
      $display("FAIL rearm got en=%b trig=%b armed=%b tt=%0d exp 0 0 1 0",
               w_enable, triggered, armed, trig_time);
    end
    set_cfg(32'h0, 32'h0, 32'h0, 1, 10);
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, $urandom, 1'b0);
      n_vec++;
      if ({w_in, w_enable, armed, triggered, trig_time} !== expected()) begin
        n_err++;
        $display("FAIL delay cyc=%0d got=%h exp=%h", cyc,
                 {w_in, w_enable, armed, triggered, trig_time}, expected());
      end
    end
    tick(1'b1, 1'b0, $urandom, 1'b1);
    n_vec++;
    if ({w_in, w_enable, armed, triggered, trig_time} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_delay got=%h exp=0", {w_in, w_enable, armed, triggered, trig_time});
    end
  endtask

  task automatic test_trig_time();
    set_cfg(32'hFF, 32'hAA, 32'h0, 1, 0);
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int i = 1; i < 1000; i++) tick(1'b0, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b0, 32'hAA, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, $urandom, 1'b0);
      n_vec++;
      if (trig_time !== 32'd1000 || w_enable !== 1'b1 ||
          {w_in, w_enable, armed, triggered, trig_time} !== expected()) begin
        n_err++;
        $display("FAIL trig_time got tt=%0d en=%b exp tt=1000 en=1", trig_time, w_enable);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      set_cfg(W'($urandom_range(0, 3)), W'($urandom_range(0, 3)), W'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      tick($urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0, $urandom,
           $urandom_range(0, 399) == 0);
      n_vec++;
      if ({w_in, w_enable, armed, triggered, trig_time} !== expected()) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc,
                 {w_in, w_enable, armed, triggered, trig_time}, expected());
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    m_active = 1'b0; m_trig = 1'b0; m_arm = 0; m_final = -1; m_tt = 0;
    m_matches = 0; m_need = 1; m_delay = 0;
    m_mask = '0; m_val = '0; m_edg = '0; m_prev = '0;
    reset = 1'b1; arm = 1'b0; disarm = 1'b0; probe = '0;
    set_cfg('0, '0, '0, 0, 0);
    test_reset();
    test_level();
    test_edge();
    test_count_delay();
    test_abort();
    test_rearm_reset();
    test_trig_time();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
